// File: rtl/sample_iter_pkg.sv
// Shared types, sizes and the MSAA stride decode for the sample iterator.
package sample_iter_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [SIGFIG-1:0] sig_t;
  typedef logic signed [SIGFIG:0]   sig_ext_t;

  typedef enum logic [0:0] {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } iter_state_t;

  localparam sig_t ONE = 24'sd1;

  // One-hot MSAA select to sample stride; anything not one-hot falls back to 1spp.
  function automatic sig_t stride_decode(input logic [3:0] sub);
    sig_t s;
    case (sub)
      4'b1000: s = ONE << RADIX;
      4'b0100: s = ONE << (RADIX - 1);
      4'b0010: s = ONE << (RADIX - 2);
      4'b0001: s = ONE << (RADIX - 3);
      default: s = ONE << RADIX;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/sample_iterator_if.sv
// Bundle between bounding-box generation, the sample iterator and sample test.
interface sample_iterator_if;
  import sample_iter_pkg::*;

  sig_t        tri_R13S   [VERTS][AXIS];
  sig_t        color_R13U [COLORS];
  sig_t        box_R13S   [2][2];
  logic        validTri_R13H;
  logic [3:0]  subSample_RnnnnU;
  logic        stall_R14H;
  logic        halt_RnnnnH;
  sig_t        tri_R14S   [VERTS][AXIS];
  sig_t        color_R14U [COLORS];
  sig_t        sample_R14S [2];
  logic        validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_step.sv
// Next raster-order sample position; adds and compares run one bit wider so
// boxes touching the positive limit never wrap.
module sample_step
  import sample_iter_pkg::*;
(
  input  sig_t i_sample [2],
  input  sig_t i_box    [2][2],
  input  sig_t i_stride,
  output sig_t o_next   [2],
  output logic o_at_end_x,
  output logic o_at_end_y
);
  sig_ext_t w_x_n;
  sig_ext_t w_y_n;
  sig_ext_t w_ur_x;
  sig_ext_t w_ur_y;
  sig_ext_t w_stride;

  assign w_stride   = {1'b0, i_stride};
  assign w_x_n      = {i_sample[0][SIGFIG-1], i_sample[0]} + w_stride;
  assign w_y_n      = {i_sample[1][SIGFIG-1], i_sample[1]} + w_stride;
  assign w_ur_x     = {i_box[1][0][SIGFIG-1], i_box[1][0]};
  assign w_ur_y     = {i_box[1][1][SIGFIG-1], i_box[1][1]};
  assign o_at_end_x = (w_x_n > w_ur_x);
  assign o_at_end_y = (w_y_n > w_ur_y);

  always_comb begin
    o_next[0] = i_sample[0];
    o_next[1] = i_sample[1];
    if (o_at_end_x) begin
      o_next[0] = i_box[0][0];
      o_next[1] = w_y_n[SIGFIG-1:0];
    end else begin
      o_next[0] = w_x_n[SIGFIG-1:0];
      o_next[1] = i_sample[1];
    end
  end
endmodule

// File: rtl/sample_iterator.sv
// Accepts one triangle + snapped box per handshake and walks every subsample in
// the box row-major, presenting one sample per unstalled cycle to sample test.
module sample_iterator
  import sample_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sample_iterator_if.slave  bus
);
  iter_state_t r_state;
  iter_state_t w_state_nxt;
  sig_t        r_tri    [VERTS][AXIS];
  sig_t        r_color  [COLORS];
  sig_t        r_box    [2][2];
  sig_t        r_stride;
  sig_t        r_sample [2];
  sig_t        w_next   [2];
  logic        w_at_end_x;
  logic        w_at_end_y;
  logic        w_empty;
  logic        w_accept;
  logic        w_advance;

  sample_step u_step (
    .i_sample   (r_sample),
    .i_box      (r_box),
    .i_stride   (r_stride),
    .o_next     (w_next),
    .o_at_end_x (w_at_end_x),
    .o_at_end_y (w_at_end_y)
  );

  // An inverted box is consumed in WAIT_STATE without producing samples.
  assign w_empty = (bus.box_R13S[1][0] < bus.box_R13S[0][0]) ||
                   (bus.box_R13S[1][1] < bus.box_R13S[0][1]);

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      WAIT_STATE: begin
        if (bus.validTri_R13H && !w_empty) begin
          w_accept    = 1'b1;
          w_state_nxt = TEST_STATE;
        end else begin
          w_state_nxt = WAIT_STATE;
        end
      end
      TEST_STATE: begin
        if (!bus.stall_R14H) begin
          w_advance   = 1'b1;
          w_state_nxt = (w_at_end_x && w_at_end_y) ? WAIT_STATE : TEST_STATE;
        end else begin
          w_state_nxt = TEST_STATE;
        end
      end
      default: w_state_nxt = WAIT_STATE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= WAIT_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held triangle data, latched stride and the walking sample position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tri    <= '{default: '{default: '0}};
      r_color  <= '{default: '0};
      r_box    <= '{default: '{default: '0}};
      r_stride <= '0;
      r_sample <= '{default: '0};
    end else if (w_accept) begin
      r_tri       <= bus.tri_R13S;
      r_color     <= bus.color_R13U;
      r_box       <= bus.box_R13S;
      r_stride    <= stride_decode(bus.subSample_RnnnnU);
      r_sample[0] <= bus.box_R13S[0][0];
      r_sample[1] <= bus.box_R13S[0][1];
    end else if (w_advance) begin
      r_sample <= w_next;
    end
  end

  assign bus.tri_R14S       = r_tri;
  assign bus.color_R14U     = r_color;
  assign bus.sample_R14S    = r_sample;
  assign bus.halt_RnnnnH    = (r_state == TEST_STATE);
  assign bus.validSamp_R14H = (r_state == TEST_STATE);
endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench: directed cases plus randomized boxes against a loop-based
// enumeration of the expected sample raster.
module tb_sample_iterator;
  import sample_iter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  sig_t exp_tri [VERTS][AXIS];
  sig_t exp_col [COLORS];

  sample_iterator_if bus ();

  sample_iterator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int model_stride(input logic [3:0] s);
    if (s == 4'b0100) return 512;
    if (s == 4'b0010) return 256;
    if (s == 4'b0001) return 128;
    return 1024;
  endfunction

  task automatic drive_tri(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) begin
        exp_tri[v][a] = sig_t'($urandom());
        bus.tri_R13S[v][a] = exp_tri[v][a];
      end
    for (int c = 0; c < COLORS; c++) begin
      exp_col[c] = sig_t'($urandom());
      bus.color_R13U[c] = exp_col[c];
    end
    bus.box_R13S[0][0] = sig_t'(llx);
    bus.box_R13S[0][1] = sig_t'(lly);
    bus.box_R13S[1][0] = sig_t'(urx);
    bus.box_R13S[1][1] = sig_t'(ury);
    bus.subSample_RnnnnU = sub;
    bus.validTri_R13H = 1'b1;
  endtask

  // stall_mode: 0 none, 1 random, 2 two-cycle stall on the third sample
  task automatic run_walk(input string name, input int llx, input int lly, input int urx,
                          input int ury, input logic [3:0] sub, input int stall_mode);
    int xs[$];
    int ys[$];
    int st, idx, cyc, nstall, halt_cnt;
    logic s, bad;
    st = model_stride(sub);
    for (int y = lly; y <= ury; y += st)
      for (int x = llx; x <= urx; x += st) begin
        xs.push_back(x);
        ys.push_back(y);
      end
    drive_tri(llx, lly, urx, ury, sub);
    @(posedge clk); #1;
    bus.validTri_R13H = 1'b0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) bus.tri_R13S[v][a] = sig_t'($urandom());
    for (int c = 0; c < COLORS; c++) bus.color_R13U[c] = sig_t'($urandom());
    bus.box_R13S[1][0] = sig_t'($urandom());
    bus.subSample_RnnnnU = (sub == 4'b0001) ? 4'b1000 : 4'b0001;
    idx = 0; cyc = 0; nstall = 0; halt_cnt = 0;
    while (idx < xs.size() && cyc < 4000) begin
      checks++;
      if (bus.validSamp_R14H !== 1'b1 || bus.halt_RnnnnH !== 1'b1) begin
        errors++;
        $display("FAIL %s valid/halt idx %0d got %b/%b exp 1/1", name, idx,
                 bus.validSamp_R14H, bus.halt_RnnnnH);
      end
      checks++;
      if (bus.sample_R14S[0] !== sig_t'(xs[idx]) || bus.sample_R14S[1] !== sig_t'(ys[idx])) begin
        errors++;
        $display("FAIL %s sample idx %0d got (%0d,%0d) exp (%0d,%0d)", name, idx,
                 bus.sample_R14S[0], bus.sample_R14S[1], xs[idx], ys[idx]);
      end
      bad = 1'b0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) if (bus.tri_R14S[v][a] !== exp_tri[v][a]) bad = 1'b1;
      for (int c = 0; c < COLORS; c++) if (bus.color_R14U[c] !== exp_col[c]) bad = 1'b1;
      checks++;
      if (bad !== 1'b0) begin
        errors++;
        $display("FAIL %s held tri/colour idx %0d got tri00 %0d col0 %0d exp %0d %0d", name,
                 idx, bus.tri_R14S[0][0], bus.color_R14U[0], exp_tri[0][0], exp_col[0]);
      end
      if (bus.halt_RnnnnH === 1'b1) halt_cnt++;
      if (stall_mode == 1) s = ($urandom_range(0, 3) == 0);
      else if (stall_mode == 2) s = (idx == 2 && nstall < 2);
      else s = 1'b0;
      bus.stall_R14H = s;
      @(posedge clk); #1;
      if (s) nstall++;
      else idx++;
      cyc++;
    end
    bus.stall_R14H = 1'b0;
    checks++;
    if (idx != xs.size()) begin
      errors++;
      $display("FAIL %s cycle budget got %0d samples exp %0d", name, idx, xs.size());
    end
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) begin
      errors++;
      $display("FAIL %s end-of-walk valid/halt got %b/%b exp 0/0", name,
               bus.validSamp_R14H, bus.halt_RnnnnH);
    end
    checks++;
    if (halt_cnt != xs.size() + nstall) begin
      errors++;
      $display("FAIL %s halt cycles got %0d exp %0d", name, halt_cnt, xs.size() + nstall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_tri(0, 0, 1024, 1024, 4'b1000);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0 ||
        bus.sample_R14S[0] !== sig_t'(0) || bus.sample_R14S[1] !== sig_t'(0) ||
        bus.tri_R14S[0][0] !== sig_t'(0) || bus.color_R14U[0] !== sig_t'(0)) begin
      errors++;
      $display("FAIL reset outputs got v%b h%b s(%0d,%0d) exp all 0", bus.validSamp_R14H,
               bus.halt_RnnnnH, bus.sample_R14S[0], bus.sample_R14S[1]);
    end
    bus.validTri_R13H = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    drive_tri(2048, 0, 1024, 1024, 4'b1000);
    @(posedge clk); #1;
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) begin
      errors++;
      $display("FAIL empty box valid/halt got %b/%b exp 0/0", bus.validSamp_R14H,
               bus.halt_RnnnnH);
    end
    run_walk("after_empty", 0, 0, 1024, 0, 4'b1000, 0);
  endtask

  task automatic test_mid_reset();
    drive_tri(0, 0, 2048, 1024, 4'b1000);
    @(posedge clk); #1;
    bus.validTri_R13H = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.sample_R14S[0] !== sig_t'(1024) || bus.validSamp_R14H !== 1'b1) begin
      errors++;
      $display("FAIL midreset second sample got x %0d v %b exp 1024 1", bus.sample_R14S[0],
               bus.validSamp_R14H);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0 ||
        bus.sample_R14S[0] !== sig_t'(0) || bus.tri_R14S[2][2] !== sig_t'(0) ||
        bus.color_R14U[2] !== sig_t'(0)) begin
      errors++;
      $display("FAIL midreset outputs got v%b h%b x %0d exp 0 0 0", bus.validSamp_R14H,
               bus.halt_RnnnnH, bus.sample_R14S[0]);
    end
    rst = 1'b1;
    run_walk("after_midreset", 0, 0, 512, 512, 4'b0100, 0);
  endtask

  task automatic test_random();
    logic [3:0] subs [6];
    subs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100};
    for (int t = 0; t < 30; t++) begin
      logic [3:0] sub;
      int st, nx, ny, llx, lly, urx, ury;
      sub = subs[$urandom_range(0, 5)];
      st  = model_stride(sub);
      nx  = $urandom_range(1, 4);
      ny  = $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) begin
        urx = 8388607 - int'($urandom_range(0, 3));
        ury = 8388607 - int'($urandom_range(0, 3));
        llx = urx - (nx - 1) * st - int'($urandom_range(0, st - 1));
        lly = ury - (ny - 1) * st - int'($urandom_range(0, st - 1));
      end else begin
        llx = int'($urandom_range(0, 40000)) - 20000;
        lly = int'($urandom_range(0, 40000)) - 20000;
        urx = llx + (nx - 1) * st + int'($urandom_range(0, st - 1));
        ury = lly + (ny - 1) * st + int'($urandom_range(0, st - 1));
      end
      if ($urandom_range(0, 4) == 0) begin
        drive_tri(llx + st, lly, llx, ury, sub);
        @(posedge clk); #1;
        bus.validTri_R13H = 1'b0;
        checks++;
        if (bus.validSamp_R14H !== 1'b0) begin
          errors++;
          $display("FAIL random empty got valid %b exp 0", bus.validSamp_R14H);
        end
      end
      run_walk("random", llx, lly, urx, ury, sub, 1);
    end
  endtask

  initial begin
    bus.validTri_R13H = 1'b0;
    bus.stall_R14H = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.tri_R13S = '{default: '{default: '0}};
    bus.color_R13U = '{default: '0};
    bus.box_R13S = '{default: '{default: '0}};
    test_reset();
    run_walk("case1_1spp", 0, 0, 2048, 1024, 4'b1000, 0);
    run_walk("case2_4spp", 0, 0, 512, 512, 4'b0100, 0);
    test_empty();
    run_walk("case4_stall", 0, 0, 2048, 1024, 4'b1000, 2);
    test_mid_reset();
    run_walk("case6_single", 5120, 3072, 5120, 3072, 4'b1000, 0);
    run_walk("back_to_back", -1024, -1024, 0, 0, 4'b0010, 0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
